// File: rtl/wb_stage_p_if.sv
// Write-back stage bus: MEM->WB payload, CP0 read/write ports, commit strobes,
// regfile write, forwarding and trace outputs.
interface wb_stage_p_if #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int EXCODE_W = 5
);
  logic                ms_to_ws_valid;
  logic                ws_allowin;
  logic [DATA_W-1:0]   ms_pc;
  logic                ms_gr_we;
  logic [RADDR_W-1:0]  ms_dest;
  logic [DATA_W-1:0]   ms_result;
  logic [2:0]          ms_ld_type;
  logic [1:0]          ms_ld_addr_lo;
  logic [DATA_W-1:0]   ms_mem_rdata;
  logic                ms_res_from_cp0;
  logic                ms_mtc0_we;
  logic [4:0]          ms_cp0_addr;
  logic [DATA_W-1:0]   ms_rt_value;
  logic                ms_ex;
  logic [EXCODE_W-1:0] ms_excode;
  logic [DATA_W-1:0]   ms_badvaddr;
  logic                ms_bd;
  logic                ms_eret;
  logic [4:0]          cp0_raddr;
  logic [DATA_W-1:0]   cp0_rdata;
  logic                cp0_we;
  logic [4:0]          cp0_waddr;
  logic [DATA_W-1:0]   cp0_wdata;
  logic                ws_ex;
  logic [EXCODE_W-1:0] ws_excode;
  logic [DATA_W-1:0]   ws_badvaddr;
  logic                ws_bd;
  logic [DATA_W-1:0]   ws_pc;
  logic                ws_eret;
  logic                rf_we;
  logic [RADDR_W-1:0]  rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                ws_fwd_valid;
  logic [RADDR_W-1:0]  ws_fwd_dest;
  logic [DATA_W-1:0]   ws_fwd_data;
  logic                ws_fwd_pending;
  logic [DATA_W-1:0]   debug_wb_pc;
  logic [3:0]          debug_wb_rf_wen;
  logic [RADDR_W-1:0]  debug_wb_rf_wnum;
  logic [DATA_W-1:0]   debug_wb_rf_wdata;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ld_type,
           ms_ld_addr_lo, ms_mem_rdata, ms_res_from_cp0, ms_mtc0_we, ms_cp0_addr,
           ms_rt_value, ms_ex, ms_excode, ms_badvaddr, ms_bd, ms_eret, cp0_rdata,
    input  ws_allowin, cp0_raddr, cp0_we, cp0_waddr, cp0_wdata, ws_ex, ws_excode,
           ws_badvaddr, ws_bd, ws_pc, ws_eret, rf_we, rf_waddr, rf_wdata,
           ws_fwd_valid, ws_fwd_dest, ws_fwd_data, ws_fwd_pending, debug_wb_pc,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ld_type,
           ms_ld_addr_lo, ms_mem_rdata, ms_res_from_cp0, ms_mtc0_we, ms_cp0_addr,
           ms_rt_value, ms_ex, ms_excode, ms_badvaddr, ms_bd, ms_eret, cp0_rdata,
    output ws_allowin, cp0_raddr, cp0_we, cp0_waddr, cp0_wdata, ws_ex, ws_excode,
           ws_badvaddr, ws_bd, ws_pc, ws_eret, rf_we, rf_waddr, rf_wdata,
           ws_fwd_valid, ws_fwd_dest, ws_fwd_data, ws_fwd_pending, debug_wb_pc,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_stage_p.sv
// Write-back stage: aligns load data, waits out the CP0 read latency for mfc0,
// commits to regfile/CP0 and raises a one-cycle flush on exception or eret.
module wb_stage_p #(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int EXCODE_W   = 5,
  parameter int CP0_RD_LAT = 1
) (
  input  logic         clk,
  input  logic         resetn,
  wb_stage_p_if.slave  bus
);
  localparam logic [1:0] LAT_C = 2'(CP0_RD_LAT);

  logic                r_ws_valid;
  logic [1:0]          r_rd_cnt;
  logic [DATA_W-1:0]   r_pc;
  logic                r_gr_we;
  logic [RADDR_W-1:0]  r_dest;
  logic [DATA_W-1:0]   r_result;
  logic [2:0]          r_ld_type;
  logic [1:0]          r_ld_addr_lo;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_res_from_cp0;
  logic                r_mtc0_we;
  logic [4:0]          r_cp0_addr;
  logic [DATA_W-1:0]   r_rt_value;
  logic                r_ex;
  logic [EXCODE_W-1:0] r_excode;
  logic [DATA_W-1:0]   r_badvaddr;
  logic                r_bd;
  logic                r_eret;

  logic                w_ready_go;
  logic                w_commit;
  logic                w_accept;
  logic                w_flush;
  logic                w_ws_ex;
  logic                w_ws_eret;
  logic                w_rf_we;
  logic                w_fwd_valid;
  logic [DATA_W-1:0]   w_load_data;
  logic [DATA_W-1:0]   w_rf_wdata;

  function automatic logic [DATA_W-1:0] align_load(
    input logic [2:0]        ld_type,
    input logic [1:0]        lo,
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] result
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (ld_type)
      3'd1:    r = word;
      3'd2:    r = {{(DATA_W-8){b[7]}}, b};
      3'd3:    r = {{(DATA_W-8){1'b0}}, b};
      3'd4:    r = {{(DATA_W-16){h[15]}}, h};
      3'd5:    r = {{(DATA_W-16){1'b0}}, h};
      default: r = result;
    endcase
    return r;
  endfunction

  // With CP0_RD_LAT=0 the counter never leaves 0, so mfc0 is ready at once.
  assign w_ready_go  = !r_res_from_cp0 || (r_rd_cnt == LAT_C);
  assign w_commit    = r_ws_valid && w_ready_go;
  assign w_accept    = bus.ms_to_ws_valid && bus.ws_allowin;
  assign w_ws_ex     = w_commit && r_ex;
  assign w_ws_eret   = w_commit && r_eret && !r_ex;
  assign w_flush     = w_ws_ex || w_ws_eret;
  assign w_rf_we     = w_commit && r_gr_we && !r_ex;
  assign w_fwd_valid = r_ws_valid && r_gr_we && !r_ex;
  assign w_load_data = align_load(r_ld_type, r_ld_addr_lo, r_mem_rdata, r_result);
  assign w_rf_wdata  = r_res_from_cp0 ? bus.cp0_rdata : w_load_data;

  // Occupancy and CP0 wait counter; a flush drops whatever MEM offers that cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ws_valid <= 1'b0;
      r_rd_cnt   <= 2'd0;
    end else if (w_flush) begin
      r_ws_valid <= 1'b0;
      r_rd_cnt   <= 2'd0;
    end else if (w_accept) begin
      r_ws_valid <= 1'b1;
      r_rd_cnt   <= 2'd0;
    end else if (w_commit) begin
      r_ws_valid <= 1'b0;
    end else if (r_ws_valid && r_res_from_cp0 && !w_ready_go) begin
      r_rd_cnt <= r_rd_cnt + 2'd1;
    end
  end

  // Payload capture; contents are only meaningful while r_ws_valid is set.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc           <= bus.ms_pc;
      r_gr_we        <= bus.ms_gr_we;
      r_dest         <= bus.ms_dest;
      r_result       <= bus.ms_result;
      r_ld_type      <= bus.ms_ld_type;
      r_ld_addr_lo   <= bus.ms_ld_addr_lo;
      r_mem_rdata    <= bus.ms_mem_rdata;
      r_res_from_cp0 <= bus.ms_res_from_cp0;
      r_mtc0_we      <= bus.ms_mtc0_we;
      r_cp0_addr     <= bus.ms_cp0_addr;
      r_rt_value     <= bus.ms_rt_value;
      r_ex           <= bus.ms_ex;
      r_excode       <= bus.ms_excode;
      r_badvaddr     <= bus.ms_badvaddr;
      r_bd           <= bus.ms_bd;
      r_eret         <= bus.ms_eret;
    end
  end

  assign bus.ws_allowin        = !r_ws_valid || w_ready_go;
  assign bus.cp0_raddr         = r_cp0_addr;
  assign bus.cp0_we            = w_commit && r_mtc0_we && !r_ex;
  assign bus.cp0_waddr         = r_cp0_addr;
  assign bus.cp0_wdata         = r_rt_value;
  assign bus.ws_ex             = w_ws_ex;
  assign bus.ws_excode         = r_excode;
  assign bus.ws_badvaddr       = r_badvaddr;
  assign bus.ws_bd             = r_bd;
  assign bus.ws_pc             = r_pc;
  assign bus.ws_eret           = w_ws_eret;
  assign bus.rf_we             = w_rf_we;
  assign bus.rf_waddr          = r_dest;
  assign bus.rf_wdata          = w_rf_wdata;
  assign bus.ws_fwd_valid      = w_fwd_valid;
  assign bus.ws_fwd_dest       = r_dest;
  assign bus.ws_fwd_data       = w_rf_wdata;
  assign bus.ws_fwd_pending    = w_fwd_valid && !w_ready_go;
  assign bus.debug_wb_pc       = r_pc;
  assign bus.debug_wb_rf_wen   = {4{w_rf_we}};
  assign bus.debug_wb_rf_wnum  = r_dest;
  assign bus.debug_wb_rf_wdata = w_rf_wdata;
endmodule
